// File: rtl/sbox_share_scheduler.sv
// Round-robin scheduler that time-shares one pipelined two-share masked AES S-box core
// among N_REQ byte requesters, keeping share 0 and share 1 in disjoint datapaths.
module sbox_share_scheduler #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int RND_W = 8,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   din0,
    input  logic [8*N_REQ-1:0]   din1,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     busy,
    input  logic [RND_W-1:0]     rnd,
    input  logic                 rnd_valid,
    output logic                 rnd_ack,
    input  logic                 flush,
    output logic [7:0]           sb_in0,
    output logic [7:0]           sb_in1,
    output logic [RND_W-1:0]     sb_rnd,
    input  logic [7:0]           sb_out0,
    input  logic [7:0]           sb_out1,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp0,
    output logic [7:0]           rsp1
);

    logic [N_REQ-1:0] busy_q, busy_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [7:0]       sb_in0_q, sb_in0_d;
    logic [7:0]       sb_in1_q, sb_in1_d;
    logic [RND_W-1:0] sb_rnd_q, sb_rnd_d;
    logic [LAT:0]     tag_v_q, tag_v_d;
    logic [ID_W-1:0]  tag_id_q [LAT+1];
    logic [ID_W-1:0]  tag_id_d [LAT+1];

    logic [N_REQ-1:0] eligible;
    logic             any_elig;
    logic             issue;
    logic [ID_W-1:0]  win;
    logic [ID_W:0]    scan;

    assign eligible = req & ~busy_q;

    // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        win      = '0;
        any_elig = 1'b0;
        scan     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(N_REQ)) begin
                scan = scan - (ID_W+1)'(N_REQ);
            end
            if (!any_elig && eligible[scan[ID_W-1:0]]) begin
                any_elig = 1'b1;
                win      = scan[ID_W-1:0];
            end
        end
    end

    assign issue   = any_elig & rnd_valid & ~flush;
    assign gnt     = issue ? (N_REQ'(1) << win) : '0;
    assign rnd_ack = issue;

    // Share datapaths: separate one-hot AND-OR muxes, selected only by the grant.
    always_comb begin
        sb_in0_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sb_in0_d = sb_in0_d | din0[8*i +: 8];
            end
        end
    end

    always_comb begin
        sb_in1_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sb_in1_d = sb_in1_d | din1[8*i +: 8];
            end
        end
    end

    assign sb_rnd_d = issue ? rnd : '0;

    always_comb begin
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        tag_v_d     = {tag_v_q[LAT-1:0], issue};
        tag_id_d[0] = issue ? win : '0;
        for (int s = 1; s <= LAT; s++) begin
            tag_id_d[s] = tag_id_q[s-1];
        end
        if (tag_v_q[LAT]) begin
            busy_d[tag_id_q[LAT]] = 1'b0;
        end
        if (issue) begin
            busy_d = busy_d | gnt;
            ptr_d  = (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
        end
        if (flush) begin
            busy_d  = '0;
            tag_v_d = '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_id_d[s] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            ptr_q    <= '0;
            sb_in0_q <= '0;
            sb_in1_q <= '0;
            sb_rnd_q <= '0;
            tag_v_q  <= '0;
            // NOTE: the tag array is tiny control state, so it is reset like any other flop.
            for (int s = 0; s <= LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            sb_in0_q <= sb_in0_d;
            sb_in1_q <= sb_in1_d;
            sb_rnd_q <= sb_rnd_d;
            tag_v_q  <= tag_v_d;
            for (int s = 0; s <= LAT; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
        end
    end

    assign busy      = busy_q;
    assign sb_in0    = sb_in0_q;
    assign sb_in1    = sb_in1_q;
    assign sb_rnd    = sb_rnd_q;
    assign rsp_valid = tag_v_q[LAT];
    assign rsp_id    = tag_id_q[LAT];
    assign rsp0      = sb_out0 & {8{rsp_valid}};
    assign rsp1      = sb_out1 & {8{rsp_valid}};

endmodule

// File: doc/sbox_share_scheduler.md
# sbox_share_scheduler

Round-robin scheduler that time-shares one externally instantiated, fully pipelined, two-share masked AES S-box core (3 register stages, affine output stage included) among N_REQ byte requesters. Selects one request per cycle, registers the two input shares and fresh randomness into the core, tracks every in-flight byte with a tag pipeline, and returns each result share pair to its owner with an ID. Shares stay in separate datapaths end to end: no signal ever depends on both share 0 and share 1.

## Interface
- N_REQ, 4, number of requesters (2..8)
- LAT, 3, core latency in cycles from sb_in* sampled to sb_out* valid
- RND_W, 8, fresh-randomness bits consumed per S-box evaluation
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  request per requester, level, held until gnt
- din0  in  8*N_REQ  share-0 input byte of requester i at [8i+7:8i]
- din1  in  8*N_REQ  share-1 input byte, same packing
- gnt  out  N_REQ  one-hot grant, combinational, issue cycle
- busy  out  N_REQ  registered, requester has a byte in flight
- rnd  in  RND_W  fresh randomness
- rnd_valid  in  1  rnd usable this cycle
- rnd_ack  out  1  combinational, rnd consumed this cycle
- flush  in  1  synchronous discard of all in-flight work
- sb_in0, sb_in1  out  8  registered share inputs to core
- sb_rnd  out  RND_W  registered randomness to core
- sb_out0, sb_out1  in  8  core output shares
- rsp_valid  out  1  result valid, one-cycle pulse
- rsp_id  out  clog2(N_REQ)  owner of result
- rsp0, rsp1  out  8  result shares, sb_out* ANDed per bit with rsp_valid

## Operation
- Eligible i: req[i] & ~busy[i]. Issue when any eligible, rnd_valid=1, flush=0.
- Arbiter: round-robin; search starts at index ptr, wraps modulo N_REQ; first eligible wins. On issue ptr <= winner+1 (wraps to 0). No issue: ptr unchanged.
- On issue: gnt[winner]=1, rnd_ack=1; next edge sb_in0/1 <= din0/din1 slice of winner, sb_rnd <= rnd, busy[winner] <= 1, tag stage 0 <= {1, winner}.
- No issue: gnt=0, rnd_ack=0; next edge sb_in0/1, sb_rnd <= 0 (idle drives all-zero shares, never holds stale data), tag stage 0 valid <= 0.
- Tag pipeline: LAT+1 stages of {valid, id}, shifts every cycle (no stall; core never stalls). Last stage drives rsp_valid/rsp_id.
- busy[rsp_id] clears on the edge ending the rsp_valid cycle; requester re-eligible from the next cycle (no same-cycle regrant).
- Share-0 path (din0→sb_in0, sb_out0→rsp0) and share-1 path use separate muxes/registers; mux select derives only from req/busy/ptr/tags.
- flush=1: no issue that cycle; next edge clears all tag valids and busy; sb_in*, sb_rnd <= 0; ptr unchanged. Core outputs of discarded bytes suppressed (rsp_valid=0 gates rsp*).
- rnd_valid=0 with eligible requesters: stall, gnt=0, ptr held.

## Timing
- Reset (async, rst_n=0): busy=0, all tag valids=0, ptr=0, sb_in0=sb_in1=0, sb_rnd=0, rsp_valid=0, rsp_id=0, rsp0=rsp1=0; gnt=0, rnd_ack=0 combinationally while all tags/busy cleared only if req=0 — gnt follows req after release. Reset mid-operation drops in-flight bytes silently.
- Issue in cycle t → sb_in* valid t+1 → sb_out* valid t+1+LAT → rsp_valid in cycle t+LAT+1 (4 with defaults).
- Throughput: one issue per cycle; a single requester at most one byte per LAT+2 cycles.
- gnt, rnd_ack combinational from req, busy, ptr, rnd_valid, flush; requester may drop req the cycle after gnt.

## Test plan
- Reset release, req=0: all outputs 0; assert req[2]=1, din0[23:16]=0x53^0xA5, din1[23:16]=0xA5, rnd_valid=1 → gnt=0100 same cycle, rsp_valid 4 cycles later, rsp_id=2, rsp0^rsp1=0xED.
- req=1111 held, rnd_valid=1 continuous: grants 0,1,2,3 in consecutive cycles, then idle until busy clears, regrant order 0,1,2,3; each rsp0^rsp1 = AES S-box of unmasked input.
- rnd_valid toggled 1,0,0,1 with req=0011: grants only in rnd_valid cycles, rnd_ack matches gnt, ptr not advanced during stalls.
- flush one cycle after two issues: no rsp_valid for those bytes, busy=0 next cycle, requesters regranted following cycle.
- rst_n low 2 cycles after issue: rsp_valid never pulses for it; post-reset first grant goes to lowest eligible index.
- Idle cycles: sb_in0=sb_in1=0, sb_rnd=0; random masks across 1000 bytes, every rsp0^rsp1 equals S-box(din0^din1), no rsp during tag-empty cycles.
